// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
//   Shared definitions for the BIST pattern generator / checker pair:
//   checker state encoding, pattern-select codes and the per-width LFSR tap
//   masks. No ports (package).
// ---------------------------------------------------------------------------
package bist_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_LOCKED = 2'd2
    } bist_state_t;

    // pattern_sel encodings
    localparam logic PAT_INC  = 1'b0;
    localparam logic PAT_LFSR = 1'b1;

    // Tap masks (bit set = tap). Feedback is the XNOR of the tapped bits.
    localparam logic [63:0] TAPS_W8  = 64'h0000_0000_0000_00B8; // 7,5,4,3
    localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_D008; // 15,14,12,3
    localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003; // 31,21,1,0
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000; // 63,62,60,59

    // Tap mask for a given word width; zero marks an unsupported width.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] taps;
        case (width)
            8:       taps = TAPS_W8;
            16:      taps = TAPS_W16;
            32:      taps = TAPS_W32;
            64:      taps = TAPS_W64;
            default: taps = 64'h0;
        endcase
        return taps;
    endfunction

    // True for the word widths that have a defined LFSR.
    function automatic logic legal_width(input int width);
        return (lfsr_taps(width) != 64'h0);
    endfunction

endpackage

// File: rtl/bist_next_word.sv
// ---------------------------------------------------------------------------
// bist_next_word
//   Combinational successor of a pattern word, shared by generator and
//   checker so both sides always agree on the sequence.
// Ports:
//   pattern_sel  in   1           0 = incremental, 1 = LFSR
//   cur          in   DATA_WIDTH  current word
//   nxt          out  DATA_WIDTH  following word in the selected pattern
// ---------------------------------------------------------------------------
module bist_next_word
    import bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pattern_sel,
    input  logic [DATA_WIDTH-1:0] cur,
    output logic [DATA_WIDTH-1:0] nxt
);

    localparam logic [63:0]           TAPS64 = lfsr_taps(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TAPS   = TAPS64[DATA_WIDTH-1:0];

    if (!legal_width(DATA_WIDTH)) begin : g_bad_width
        $error("bist_next_word: DATA_WIDTH must be 8, 16, 32 or 64");
    end

    // Successor: shift-left with XNOR feedback for LFSR, +1 (wrapping) otherwise.
    // The all-ones word maps onto itself in the LFSR (XNOR lock-up state).
    always_comb begin
        nxt = '0;
        if (pattern_sel == PAT_LFSR) begin
            nxt = {cur[DATA_WIDTH-2:0], ~(^(cur & TAPS))};
        end else begin
            nxt = cur + DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bist_checker.sv
// ---------------------------------------------------------------------------
// bist_checker
//   Receive-side BIST checker. Seeks lock on an incoming incremental or LFSR
//   stream, then free-runs its own prediction and flags/counts mismatches.
// Ports:
//   clk          in   1           clock
//   rst          in   1           synchronous active-high reset
//   enable       in   1           checker enable (0 forces IDLE)
//   pattern_sel  in   1           0 = incremental, 1 = LFSR
//   data_in      in   DATA_WIDTH  received word
//   valid_in     in   1           data_in qualifier
//   clear        in   1           zero err_cnt, word_cnt, lost_sticky
//   locked       out  1           in LOCKED state
//   error        out  1           one pulse per mismatching word while locked
//   err_cnt      out  ERR_CNT_W   saturating mismatch count
//   word_cnt     out  WORD_CNT_W  wrapping count of words checked while locked
//   lost_sticky  out  1           lock was lost since last clear/reset
//   exp_data     out  DATA_WIDTH  current expected word
// ---------------------------------------------------------------------------
module bist_checker
    import bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ERR_CNT_W  = 16,
    parameter int WORD_CNT_W = 32,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pattern_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  clear,
    output logic                  locked,
    output logic                  error,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic                  lost_sticky,
    output logic [DATA_WIDTH-1:0] exp_data
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_CNT);

    if (LOCK_CNT < 1 || LOSS_CNT < 1) begin : g_bad_cnt
        $error("bist_checker: LOCK_CNT and LOSS_CNT must be >= 1");
    end

    bist_state_t           state_r;
    logic [DATA_WIDTH-1:0] exp_r;
    logic [MATCH_W-1:0]    match_cnt_r;
    logic [MISS_W-1:0]     miss_cnt_r;
    logic [ERR_CNT_W-1:0]  err_cnt_r;
    logic [WORD_CNT_W-1:0] word_cnt_r;
    logic                  lost_sticky_r;
    logic                  error_r;
    logic                  locked_r;
    logic                  pat_sel_d_r;
    logic                  first_r;   // next SEEK word only seeds, never matches

    logic [DATA_WIDTH-1:0] next_in_s;
    logic [DATA_WIDTH-1:0] next_s;
    logic                  match_s;
    logic                  pat_change_s;
    logic [MATCH_W-1:0]    match_inc_s;
    logic [MISS_W-1:0]     miss_inc_s;
    logic [ERR_CNT_W-1:0]  err_base_s;
    logic [ERR_CNT_W-1:0]  err_inc_s;
    logic [WORD_CNT_W-1:0] word_base_s;
    logic [WORD_CNT_W-1:0] word_inc_s;
    logic                  lost_base_s;

    // Prediction source: received word while seeking, own expectation once locked
    // so a corrupted word cannot cascade into further errors.
    always_comb begin
        next_in_s = data_in;
        if (state_r == ST_LOCKED) begin
            next_in_s = exp_r;
        end else begin
            next_in_s = data_in;
        end
    end

    bist_next_word #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next (
        .pattern_sel (pattern_sel),
        .cur         (next_in_s),
        .nxt         (next_s)
    );

    // Counter arithmetic; clear zeroes the base first so a same-cycle event
    // still counts on top of it.
    always_comb begin
        match_s      = (data_in == exp_r);
        pat_change_s = (pattern_sel != pat_sel_d_r);
        match_inc_s  = match_cnt_r + MATCH_W'(1);
        miss_inc_s   = miss_cnt_r + MISS_W'(1);
        err_base_s   = '0;
        word_base_s  = '0;
        lost_base_s  = 1'b0;
        if (clear) begin
            err_base_s  = '0;
            word_base_s = '0;
            lost_base_s = 1'b0;
        end else begin
            err_base_s  = err_cnt_r;
            word_base_s = word_cnt_r;
            lost_base_s = lost_sticky_r;
        end
        if (&err_base_s) begin
            err_inc_s = err_base_s;
        end else begin
            err_inc_s = err_base_s + ERR_CNT_W'(1);
        end
        word_inc_s = word_base_s + WORD_CNT_W'(1);
    end

    // Checker FSM with expected-word register, counters and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            exp_r         <= '0;
            match_cnt_r   <= '0;
            miss_cnt_r    <= '0;
            err_cnt_r     <= '0;
            word_cnt_r    <= '0;
            lost_sticky_r <= 1'b0;
            error_r       <= 1'b0;
            locked_r      <= 1'b0;
            pat_sel_d_r   <= 1'b0;
            first_r       <= 1'b1;
        end else begin
            pat_sel_d_r   <= pattern_sel;
            error_r       <= 1'b0;
            err_cnt_r     <= err_base_s;
            word_cnt_r    <= word_base_s;
            lost_sticky_r <= lost_base_s;
            if (!enable || pat_change_s) begin
                state_r     <= ST_IDLE;
                locked_r    <= 1'b0;
                match_cnt_r <= '0;
                miss_cnt_r  <= '0;
                first_r     <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r     <= ST_SEEK;
                        match_cnt_r <= '0;
                        first_r     <= 1'b1;
                    end
                    ST_SEEK: begin
                        if (valid_in) begin
                            exp_r   <= next_s;
                            first_r <= 1'b0;
                            if (!first_r && match_s) begin
                                if (match_inc_s == LOCK_TGT) begin
                                    state_r     <= ST_LOCKED;
                                    locked_r    <= 1'b1;
                                    match_cnt_r <= '0;
                                    miss_cnt_r  <= '0;
                                end else begin
                                    match_cnt_r <= match_inc_s;
                                end
                            end else begin
                                match_cnt_r <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (valid_in) begin
                            exp_r      <= next_s;
                            word_cnt_r <= word_inc_s;
                            if (!match_s) begin
                                error_r   <= 1'b1;
                                err_cnt_r <= err_inc_s;
                                if (miss_inc_s == LOSS_TGT) begin
                                    state_r       <= ST_SEEK;
                                    locked_r      <= 1'b0;
                                    lost_sticky_r <= 1'b1;
                                    miss_cnt_r    <= '0;
                                    match_cnt_r   <= '0;
                                    first_r       <= 1'b1;
                                end else begin
                                    miss_cnt_r <= miss_inc_s;
                                end
                            end else begin
                                miss_cnt_r <= '0;
                            end
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        locked_r    <= 1'b0;
                        match_cnt_r <= '0;
                        miss_cnt_r  <= '0;
                        first_r     <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign locked      = locked_r;
    assign error       = error_r;
    assign err_cnt     = err_cnt_r;
    assign word_cnt    = word_cnt_r;
    assign lost_sticky = lost_sticky_r;
    assign exp_data    = exp_r;

endmodule

// File: tb/tb_bist_checker.sv
// ---------------------------------------------------------------------------
// tb_bist_checker
//   Directed bench for bist_checker. dut_a: 32-bit defaults (incremental
//   stream, injection, loss, clear, pattern toggle, reset). dut_b: 8-bit LFSR
//   with a 4-bit error counter and LOSS_CNT=20 (gaps, saturation, lock-up word).
// ---------------------------------------------------------------------------
module tb_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        a_rst, a_en, a_pat, a_valid, a_clear;
    logic [31:0] a_data;
    logic        a_locked, a_error, a_lost;
    logic [15:0] a_err_cnt;
    logic [31:0] a_word_cnt, a_exp;

    logic        b_rst, b_en, b_pat, b_valid, b_clear;
    logic [7:0]  b_data;
    logic        b_locked, b_error, b_lost;
    logic [3:0]  b_err_cnt;
    logic [31:0] b_word_cnt;
    logic [7:0]  b_exp;

    bist_checker dut_a (
        .clk(clk), .rst(a_rst), .enable(a_en), .pattern_sel(a_pat),
        .data_in(a_data), .valid_in(a_valid), .clear(a_clear),
        .locked(a_locked), .error(a_error), .err_cnt(a_err_cnt),
        .word_cnt(a_word_cnt), .lost_sticky(a_lost), .exp_data(a_exp)
    );

    bist_checker #(
        .DATA_WIDTH(8), .ERR_CNT_W(4), .WORD_CNT_W(32), .LOCK_CNT(4), .LOSS_CNT(20)
    ) dut_b (
        .clk(clk), .rst(b_rst), .enable(b_en), .pattern_sel(b_pat),
        .data_in(b_data), .valid_in(b_valid), .clear(b_clear),
        .locked(b_locked), .error(b_error), .err_cnt(b_err_cnt),
        .word_cnt(b_word_cnt), .lost_sticky(b_lost), .exp_data(b_exp)
    );

    // Apply one word to dut_a for one clock; outputs are stable 1 ns after the edge.
    task automatic a_cyc(input logic [31:0] d, input logic v);
        a_data = d; a_valid = v;
        @(posedge clk); #1;
    endtask

    task automatic b_cyc(input logic [7:0] d, input logic v);
        b_data = d; b_valid = v;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (a_locked !== 1'b0)  begin n_bad++; $display("FAIL reset_locked: got %0h want 0", a_locked); end
        n_cmp++; if (a_error !== 1'b0)   begin n_bad++; $display("FAIL reset_error: got %0h want 0", a_error); end
        n_cmp++; if (a_err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_cnt: got %0h want 0", a_err_cnt); end
        n_cmp++; if (a_word_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_word_cnt: got %0h want 0", a_word_cnt); end
        n_cmp++; if (a_lost !== 1'b0)    begin n_bad++; $display("FAIL reset_lost: got %0h want 0", a_lost); end
        n_cmp++; if (a_exp !== 32'h0)    begin n_bad++; $display("FAIL reset_exp: got %0h want 0", a_exp); end
        n_cmp++; if (b_locked !== 1'b0)  begin n_bad++; $display("FAIL reset_b_locked: got %0h want 0", b_locked); end
        a_rst = 1'b0; b_rst = 1'b0;
    endtask

    // T1: incremental stream 0,1,2,... locks on the 5th word.
    task automatic test_inc_lock;
        a_en = 1'b1; a_pat = 1'b0;
        a_cyc(32'h0, 1'b0);
        for (int i = 0; i < 4; i++) a_cyc(32'(i), 1'b1);
        n_cmp++; if (a_locked !== 1'b0) begin n_bad++; $display("FAIL inc_pre_lock: got %0h want 0", a_locked); end
        a_cyc(32'h4, 1'b1);
        n_cmp++; if (a_locked !== 1'b1) begin n_bad++; $display("FAIL inc_lock: got %0h want 1", a_locked); end
        n_cmp++; if (a_exp !== 32'h5)   begin n_bad++; $display("FAIL inc_exp: got %0h want 5", a_exp); end
        n_cmp++; if (a_word_cnt !== 32'h0) begin n_bad++; $display("FAIL inc_word0: got %0h want 0", a_word_cnt); end
        for (int i = 5; i <= 32'h62; i++) a_cyc(32'(i), 1'b1);
        n_cmp++; if (a_word_cnt !== 32'd94) begin n_bad++; $display("FAIL inc_word_cnt: got %0d want 94", a_word_cnt); end
        n_cmp++; if (a_err_cnt !== 16'h0)   begin n_bad++; $display("FAIL inc_err_cnt: got %0h want 0", a_err_cnt); end
        n_cmp++; if (a_exp !== 32'h63)      begin n_bad++; $display("FAIL inc_exp63: got %0h want 63", a_exp); end
    endtask

    // T2: one corrupted word gives exactly one error pulse.
    task automatic test_inject;
        a_cyc(32'h64, 1'b1);
        n_cmp++; if (a_error !== 1'b1)    begin n_bad++; $display("FAIL inj_error: got %0h want 1", a_error); end
        n_cmp++; if (a_err_cnt !== 16'h1) begin n_bad++; $display("FAIL inj_err_cnt: got %0h want 1", a_err_cnt); end
        n_cmp++; if (a_locked !== 1'b1)   begin n_bad++; $display("FAIL inj_locked: got %0h want 1", a_locked); end
        n_cmp++; if (a_word_cnt !== 32'd95) begin n_bad++; $display("FAIL inj_word: got %0d want 95", a_word_cnt); end
        a_cyc(32'h64, 1'b1);
        n_cmp++; if (a_error !== 1'b0)    begin n_bad++; $display("FAIL inj_no_cascade: got %0h want 0", a_error); end
        n_cmp++; if (a_err_cnt !== 16'h1) begin n_bad++; $display("FAIL inj_err_hold: got %0h want 1", a_err_cnt); end
        a_cyc(32'h0, 1'b0);
        n_cmp++; if (a_word_cnt !== 32'd96) begin n_bad++; $display("FAIL gap_word: got %0d want 96", a_word_cnt); end
        a_cyc(32'h65, 1'b1);
        n_cmp++; if (a_exp !== 32'h66)    begin n_bad++; $display("FAIL inj_exp: got %0h want 66", a_exp); end
        n_cmp++; if (a_word_cnt !== 32'd97) begin n_bad++; $display("FAIL inj_word2: got %0d want 97", a_word_cnt); end
    endtask

    // T4: eight wrong words lose lock; a correct stream re-locks.
    task automatic test_loss;
        a_clear = 1'b1; a_cyc(32'h0, 1'b0); a_clear = 1'b0;
        n_cmp++; if (a_err_cnt !== 16'h0) begin n_bad++; $display("FAIL clr_err_cnt: got %0h want 0", a_err_cnt); end
        n_cmp++; if (a_word_cnt !== 32'h0) begin n_bad++; $display("FAIL clr_word: got %0h want 0", a_word_cnt); end
        for (int i = 0; i < 8; i++) begin
            a_cyc(32'hFFFF_0000, 1'b1);
            if (i == 6) begin
                n_cmp++; if (a_locked !== 1'b1) begin n_bad++; $display("FAIL loss_7_locked: got %0h want 1", a_locked); end
                n_cmp++; if (a_err_cnt !== 16'h7) begin n_bad++; $display("FAIL loss_7_err: got %0h want 7", a_err_cnt); end
            end
        end
        n_cmp++; if (a_locked !== 1'b0)   begin n_bad++; $display("FAIL loss_locked: got %0h want 0", a_locked); end
        n_cmp++; if (a_lost !== 1'b1)     begin n_bad++; $display("FAIL loss_sticky: got %0h want 1", a_lost); end
        n_cmp++; if (a_err_cnt !== 16'h8) begin n_bad++; $display("FAIL loss_err: got %0h want 8", a_err_cnt); end
        n_cmp++; if (a_word_cnt !== 32'h8) begin n_bad++; $display("FAIL loss_word: got %0h want 8", a_word_cnt); end
        for (int d = 100; d < 104; d++) a_cyc(32'(d), 1'b1);
        n_cmp++; if (a_locked !== 1'b0)   begin n_bad++; $display("FAIL relock_pre: got %0h want 0", a_locked); end
        a_cyc(32'd104, 1'b1);
        n_cmp++; if (a_locked !== 1'b1)   begin n_bad++; $display("FAIL relock: got %0h want 1", a_locked); end
        n_cmp++; if (a_lost !== 1'b1)     begin n_bad++; $display("FAIL relock_sticky: got %0h want 1", a_lost); end
    endtask

    // clear coinciding with a mismatch: clear first, then count the event.
    task automatic test_clear_collide;
        a_clear = 1'b1; a_cyc(32'd999, 1'b1); a_clear = 1'b0;
        n_cmp++; if (a_err_cnt !== 16'h1) begin n_bad++; $display("FAIL cc_err: got %0h want 1", a_err_cnt); end
        n_cmp++; if (a_word_cnt !== 32'h1) begin n_bad++; $display("FAIL cc_word: got %0h want 1", a_word_cnt); end
        n_cmp++; if (a_lost !== 1'b0)     begin n_bad++; $display("FAIL cc_lost: got %0h want 0", a_lost); end
        n_cmp++; if (a_error !== 1'b1)    begin n_bad++; $display("FAIL cc_error: got %0h want 1", a_error); end
        a_cyc(32'd106, 1'b1);
        n_cmp++; if (a_error !== 1'b0)    begin n_bad++; $display("FAIL cc_next: got %0h want 0", a_error); end
        n_cmp++; if (a_word_cnt !== 32'h2) begin n_bad++; $display("FAIL cc_word2: got %0h want 2", a_word_cnt); end
    endtask

    // T6: pattern_sel toggle drops to IDLE; reset mid-stream clears everything.
    task automatic test_pat_toggle_rst;
        a_pat = 1'b1; a_cyc(32'd107, 1'b1);
        n_cmp++; if (a_locked !== 1'b0)   begin n_bad++; $display("FAIL tog_locked: got %0h want 0", a_locked); end
        n_cmp++; if (a_error !== 1'b0)    begin n_bad++; $display("FAIL tog_error: got %0h want 0", a_error); end
        n_cmp++; if (a_word_cnt !== 32'h2) begin n_bad++; $display("FAIL tog_word: got %0h want 2", a_word_cnt); end
        n_cmp++; if (a_err_cnt !== 16'h1) begin n_bad++; $display("FAIL tog_err_keep: got %0h want 1", a_err_cnt); end
        a_cyc(32'h0, 1'b0);
        a_cyc(32'h5, 1'b1);
        a_rst = 1'b1; a_cyc(32'h1234, 1'b1); a_rst = 1'b0;
        n_cmp++; if (a_err_cnt !== 16'h0)  begin n_bad++; $display("FAIL rst_err: got %0h want 0", a_err_cnt); end
        n_cmp++; if (a_word_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_word: got %0h want 0", a_word_cnt); end
        n_cmp++; if (a_exp !== 32'h0)      begin n_bad++; $display("FAIL rst_exp: got %0h want 0", a_exp); end
        n_cmp++; if (a_error !== 1'b0)     begin n_bad++; $display("FAIL rst_error: got %0h want 0", a_error); end
    endtask

    // T3: 8-bit LFSR 00,01,03,07,0F,1E,3D,7A with valid gaps.
    task automatic test_lfsr_gaps;
        b_en = 1'b1; b_pat = 1'b1;
        repeat (3) b_cyc(8'h00, 1'b0);
        b_cyc(8'h00, 1'b1); b_cyc(8'h00, 1'b0);
        b_cyc(8'h01, 1'b1); b_cyc(8'h03, 1'b1);
        b_cyc(8'h00, 1'b0); b_cyc(8'h00, 1'b0);
        b_cyc(8'h07, 1'b1);
        n_cmp++; if (b_locked !== 1'b0) begin n_bad++; $display("FAIL lfsr_pre_lock: got %0h want 0", b_locked); end
        b_cyc(8'h0F, 1'b1);
        n_cmp++; if (b_locked !== 1'b1) begin n_bad++; $display("FAIL lfsr_lock: got %0h want 1", b_locked); end
        n_cmp++; if (b_exp !== 8'h1E)   begin n_bad++; $display("FAIL lfsr_exp1e: got %0h want 1e", b_exp); end
        b_cyc(8'h1E, 1'b1); b_cyc(8'h00, 1'b0);
        n_cmp++; if (b_error !== 1'b0)  begin n_bad++; $display("FAIL lfsr_gap_err: got %0h want 0", b_error); end
        b_cyc(8'h3D, 1'b1); b_cyc(8'h7A, 1'b1); b_cyc(8'h00, 1'b0);
        n_cmp++; if (b_word_cnt !== 32'd3) begin n_bad++; $display("FAIL lfsr_word: got %0d want 3", b_word_cnt); end
        n_cmp++; if (b_err_cnt !== 4'h0)   begin n_bad++; $display("FAIL lfsr_err: got %0h want 0", b_err_cnt); end
        n_cmp++; if (b_exp !== 8'hF4)      begin n_bad++; $display("FAIL lfsr_expf4: got %0h want f4", b_exp); end
    endtask

    // T5: err_cnt saturates at 4'hF; clear zeroes it and lost_sticky.
    task automatic test_saturate;
        for (int i = 1; i <= 20; i++) begin
            b_cyc(8'hFF, 1'b1);   // all-ones never occurs in the LFSR run, so always wrong
            if (i == 14) begin
                n_cmp++; if (b_err_cnt !== 4'hE) begin n_bad++; $display("FAIL sat_14: got %0h want e", b_err_cnt); end
            end
            if (i == 15) begin
                n_cmp++; if (b_err_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_15: got %0h want f", b_err_cnt); end
            end
            if (i == 16) begin
                n_cmp++; if (b_err_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_16: got %0h want f", b_err_cnt); end
                n_cmp++; if (b_error !== 1'b1)   begin n_bad++; $display("FAIL sat_pulse: got %0h want 1", b_error); end
            end
            if (i == 19) begin
                n_cmp++; if (b_locked !== 1'b1)  begin n_bad++; $display("FAIL sat_19_locked: got %0h want 1", b_locked); end
            end
        end
        n_cmp++; if (b_locked !== 1'b0)    begin n_bad++; $display("FAIL sat_loss: got %0h want 0", b_locked); end
        n_cmp++; if (b_lost !== 1'b1)      begin n_bad++; $display("FAIL sat_lost: got %0h want 1", b_lost); end
        n_cmp++; if (b_word_cnt !== 32'd23) begin n_bad++; $display("FAIL sat_word: got %0d want 23", b_word_cnt); end
        b_clear = 1'b1; b_cyc(8'h00, 1'b0); b_clear = 1'b0;
        n_cmp++; if (b_err_cnt !== 4'h0)   begin n_bad++; $display("FAIL sat_clr_err: got %0h want 0", b_err_cnt); end
        n_cmp++; if (b_lost !== 1'b0)      begin n_bad++; $display("FAIL sat_clr_lost: got %0h want 0", b_lost); end
    endtask

    // All-ones LFSR lock-up word is an ordinary pattern; enable=0 drops to IDLE.
    task automatic test_allones_enable;
        for (int i = 0; i < 4; i++) b_cyc(8'hFF, 1'b1);
        n_cmp++; if (b_locked !== 1'b0) begin n_bad++; $display("FAIL ones_pre: got %0h want 0", b_locked); end
        b_cyc(8'hFF, 1'b1);
        n_cmp++; if (b_locked !== 1'b1) begin n_bad++; $display("FAIL ones_lock: got %0h want 1", b_locked); end
        n_cmp++; if (b_exp !== 8'hFF)   begin n_bad++; $display("FAIL ones_exp: got %0h want ff", b_exp); end
        b_en = 1'b0; b_cyc(8'h12, 1'b1);
        n_cmp++; if (b_locked !== 1'b0) begin n_bad++; $display("FAIL en_off_locked: got %0h want 0", b_locked); end
        n_cmp++; if (b_exp !== 8'hFF)   begin n_bad++; $display("FAIL en_off_exp: got %0h want ff", b_exp); end
        n_cmp++; if (b_error !== 1'b0)  begin n_bad++; $display("FAIL en_off_error: got %0h want 0", b_error); end
        n_cmp++; if (b_lost !== 1'b0)   begin n_bad++; $display("FAIL en_off_lost: got %0h want 0", b_lost); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_pat = 1'b0; a_valid = 1'b0; a_clear = 1'b0; a_data = 32'h0;
        b_rst = 1'b1; b_en = 1'b0; b_pat = 1'b0; b_valid = 1'b0; b_clear = 1'b0; b_data = 8'h0;
        test_reset();
        test_inc_lock();
        test_inject();
        test_loss();
        test_clear_collide();
        test_pat_toggle_rst();
        test_lfsr_gaps();
        test_saturate();
        test_allones_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
